// File: rtl/param_cache.sv
// N-way set-associative write-through, write-allocate cache with per-set round-robin victim choice.
// Optional hit/miss counters: define CACHE_PERF_CNT_EN.
module param_cache #(
    parameter int OFFSET_BITS = 4,
    parameter int SET_BITS    = 5,
    parameter int WAYS        = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_busy,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [3:0]  i_req_mask,
    input  logic [31:0] i_req_wdata,
`ifdef CACHE_PERF_CNT_EN
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt,
`endif
    output logic [31:0] o_res_rdata
);
    localparam int NB      = OFFSET_BITS - 2;
    localparam int LW      = 1 << NB;
    localparam int SETS    = 1 << SET_BITS;
    localparam int TAG_LSB = OFFSET_BITS + SET_BITS;
    localparam int T       = 32 - TAG_LSB;
    localparam int WB      = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RESP, S_WRITE} state_t;

    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] m);
        return (old_w & ~expand_mask(m)) | (new_w & expand_mask(m));
    endfunction

    state_t          r_state, w_next;
    logic [WAYS-1:0] r_valid [SETS];
    logic [T-1:0]    r_tag   [WAYS][SETS];
    logic [31:0]     r_data  [WAYS][SETS][LW];
    logic [WB-1:0]   r_rr    [SETS];
    logic [WB-1:0]   r_way;
    logic            r_use_rr;
    logic            r_is_write;
    logic [NB:0]     r_issue;
    logic [NB-1:0]   r_recv;
    logic [3:0]      r_mask;
    logic [31:0]     r_wdata;

    logic [T-1:0]        w_tag;
    logic [SET_BITS-1:0] w_set;
    logic [NB-1:0]       w_word;
    logic                w_req;
    logic                w_hit;
    logic [WB-1:0]       w_hit_way;
    logic [WB-1:0]       w_vict;
    logic                w_vict_rr;
    logic [WB-1:0]       w_rr_next;
    logic [31:0]         w_hit_word;
    logic [31:0]         w_cur_word;
    logic [31:0]         w_merged;
    logic                w_fill_last;
    logic                w_unused_addr_lsb;

    assign w_tag             = i_req_addr[31:TAG_LSB];
    assign w_set             = i_req_addr[TAG_LSB-1:OFFSET_BITS];
    assign w_word            = i_req_addr[OFFSET_BITS-1:2];
    assign w_unused_addr_lsb = ^i_req_addr[1:0];
    assign w_req             = i_req_ren || i_req_wen;
    assign w_hit_word        = r_data[w_hit_way][w_set][w_word];
    assign w_cur_word        = r_data[r_way][w_set][w_word];
    assign w_merged          = merge_word(w_cur_word, r_wdata, r_mask);
    assign w_rr_next         = (r_rr[w_set] == WB'(WAYS - 1)) ? '0 : r_rr[w_set] + 1'b1;
    assign w_fill_last       = (r_state == S_FILL) && i_mem_valid && (r_recv == NB'(LW - 1));

    // Tag lookup, plus victim: lowest invalid way wins over the round-robin pointer.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_vict    = r_rr[w_set];
        w_vict_rr = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_set][w] && (r_tag[w][w_set] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WB'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_set][w]) begin
                w_vict    = WB'(w);
                w_vict_rr = 1'b0;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        o_busy      = 1'b0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_res_rdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_hit && i_req_ren) begin
                        o_res_rdata = w_hit_word & expand_mask(i_req_mask);
                    end else begin
                        o_busy = 1'b1;
                        w_next = w_hit ? S_WRITE : S_FILL;
                    end
                end
            end
            S_FILL: begin
                o_busy     = 1'b1;
                o_mem_ren  = !r_issue[NB];
                o_mem_addr = {i_req_addr[31:OFFSET_BITS], r_issue[NB-1:0], 2'b00};
                if (w_fill_last) begin
                    w_next = r_is_write ? S_WRITE : S_RESP;
                end
            end
            S_RESP: begin
                o_res_rdata = w_cur_word & expand_mask(r_mask);
                w_next      = S_IDLE;
            end
            S_WRITE: begin
                o_mem_wen   = 1'b1;
                o_mem_addr  = {i_req_addr[31:2], 2'b00};
                o_mem_wdata = w_merged;
                if (i_mem_ready) begin
                    w_next = S_IDLE;
                end else begin
                    o_busy = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_way      <= '0;
            r_use_rr   <= 1'b0;
            r_is_write <= 1'b0;
            r_issue    <= '0;
            r_recv     <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
`ifdef CACHE_PERF_CNT_EN
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_way      <= w_hit ? w_hit_way : w_vict;
                        r_is_write <= i_req_wen;
                        r_use_rr   <= w_vict_rr;
                        r_issue    <= '0;
                        r_recv     <= '0;
                        if (!w_hit) begin
                            r_valid[w_set][w_vict] <= 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    if (o_mem_ren && i_mem_ready) begin
                        r_issue <= r_issue + 1'b1;
                    end
                    if (i_mem_valid) begin
                        r_recv <= r_recv + 1'b1;
                    end
                    if (w_fill_last) begin
                        r_valid[w_set][r_way] <= 1'b1;
                        if (r_use_rr) begin
                            r_rr[w_set] <= w_rr_next;
                        end
                    end
                end
                default: ;
            endcase
`ifdef CACHE_PERF_CNT_EN
            if ((r_state == S_IDLE) && w_req) begin
                if (w_hit) begin
                    o_hit_cnt <= o_hit_cnt + 32'd1;
                end else begin
                    o_miss_cnt <= o_miss_cnt + 32'd1;
                end
            end
`endif
        end
    end

    // Storage and latched request data; validity is guarded by r_valid, so no reset here.
    always_ff @(posedge i_clk) begin
        if ((r_state == S_IDLE) && w_req) begin
            r_mask  <= i_req_mask;
            r_wdata <= i_req_wdata;
        end
        if ((r_state == S_FILL) && i_mem_valid) begin
            r_data[r_way][w_set][r_recv] <= i_mem_rdata;
        end
        if (w_fill_last) begin
            r_tag[r_way][w_set] <= w_tag;
        end
        if ((r_state == S_WRITE) && i_mem_ready) begin
            r_data[r_way][w_set][w_word] <= w_merged;
        end
    end
endmodule

// File: tb/tb_param_cache.sv
// Scoreboard bench for param_cache: directed requests against a latency-2 word memory model.
`timescale 1ns/1ps
module tb_param_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_valid;
    logic        o_busy;
    logic [31:0] req_addr;
    logic        req_ren;
    logic        req_wen;
    logic [3:0]  req_mask;
    logic [31:0] req_wdata;
    logic [31:0] o_res_rdata;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] o_hit_cnt;
    logic [31:0] o_miss_cnt;
`endif

    always #5 clk = ~clk;

    param_cache dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_ready (i_mem_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_ren   (o_mem_ren),
        .o_mem_wen   (o_mem_wen),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_valid (i_mem_valid),
        .o_busy      (o_busy),
        .i_req_addr  (req_addr),
        .i_req_ren   (req_ren),
        .i_req_wen   (req_wen),
        .i_req_mask  (req_mask),
        .i_req_wdata (req_wdata),
`ifdef CACHE_PERF_CNT_EN
        .o_hit_cnt   (o_hit_cnt),
        .o_miss_cnt  (o_miss_cnt),
`endif
        .o_res_rdata (o_res_rdata)
    );

    localparam int P_BUSY = 0, P_REN = 1, P_WEN = 2, P_ADDR = 3, P_WDATA = 4, P_RDATA = 5,
                   P_RDACC = 6, P_WENCYC = 7, P_HITS = 8, P_MISSES = 9;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } probe_t;

    probe_t      probe_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_ra_q[$];
    logic [63:0] exp_wr_q[$];

    int          checks = 0;
    int          failures = 0;
    int          rd_accepts = 0;
    int          wen_cycles = 0;
    logic        chk_mem = 1'b0;
    logic        mem_load = 1'b1;
    int          rdy_low = 0;

    logic [31:0] mem  [1024];
    logic [31:0] refm [1024];
    logic [1:0]  rv = 2'b00;
    logic [31:0] rd0, rd1;
    int          wen_age = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h42) return 32'h1122_3344;
        return 32'h9E37_79B9 * 32'(i + 1);
    endfunction

    function automatic logic [31:0] emask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Memory: reads return two cycles after acceptance, in order; writes stall for rdy_low cycles.
    assign i_mem_ready = !(o_mem_wen && (wen_age < rdy_low));
    assign i_mem_valid = rv[1];
    assign i_mem_rdata = rd1;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (o_mem_wen && i_mem_ready) begin
            mem[o_mem_addr[11:2]] <= o_mem_wdata;
        end
        rv      <= {rv[0], o_mem_ren && i_mem_ready};
        rd0     <= mem[o_mem_addr[11:2]];
        rd1     <= rd0;
        wen_age <= o_mem_wen ? wen_age + 1 : 0;
    end

    function automatic logic [31:0] probe_val(input int sel);
        case (sel)
            P_BUSY:   return {31'b0, o_busy};
            P_REN:    return {31'b0, o_mem_ren};
            P_WEN:    return {31'b0, o_mem_wen};
            P_ADDR:   return o_mem_addr;
            P_WDATA:  return o_mem_wdata;
            P_RDATA:  return o_res_rdata;
            P_RDACC:  return 32'(rd_accepts);
            P_WENCYC: return 32'(wen_cycles);
`ifdef CACHE_PERF_CNT_EN
            P_HITS:   return o_hit_cnt;
            P_MISSES: return o_miss_cnt;
`endif
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: the only process that compares.
    initial begin
        probe_t      p;
        logic [63:0] w;
        forever begin
            @(negedge clk);
            if (o_mem_ren && i_mem_ready) begin
                rd_accepts++;
                if (chk_mem) begin
                    if (exp_ra_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mem_read_unexpected actual=%h required=none", o_mem_addr);
                    end else begin
                        check("mem_read_addr", o_mem_addr, exp_ra_q.pop_front());
                    end
                end
            end
            if (o_mem_wen) wen_cycles++;
            if (o_mem_wen && i_mem_ready && chk_mem) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mem_write_unexpected actual=%h required=none", o_mem_addr);
                end else begin
                    w = exp_wr_q.pop_front();
                    check("mem_write_addr", o_mem_addr, w[63:32]);
                    check("mem_write_data", o_mem_wdata, w[31:0]);
                end
            end
            if (!o_busy && (exp_rd_q.size() > 0)) begin
                check("res_rdata", o_res_rdata, exp_rd_q.pop_front());
            end
            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                check(p.name, probe_val(p.sel), p.exp);
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] wd, input logic hit, input string nm);
        int          idx;
        int          n;
        logic [31:0] m;
        idx = int'(addr[11:2]);
        @(posedge clk); #1;
        if (!hit) begin
            for (int i = 0; i < 4; i++) exp_ra_q.push_back((addr & 32'hFFFF_FFF0) + 32'(4 * i));
        end
        if (wr) begin
            m = (refm[idx] & ~emask(mask)) | (wd & emask(mask));
            refm[idx] = m;
            exp_wr_q.push_back({addr, m});
        end else begin
            exp_rd_q.push_back(refm[idx] & emask(mask));
        end
        probe_q.push_back('{nm, P_BUSY, {31'b0, wr || !hit}});
        req_addr  = addr;
        req_mask  = mask;
        req_wdata = wd;
        req_ren   = !wr;
        req_wen   = wr;
        @(posedge clk); #1;
        req_ren = 1'b0;
        req_wen = 1'b0;
        if (wr || !hit) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (o_busy && (n < 300));
            if (o_busy) probe_q.push_back('{"timeout_busy", P_BUSY, 32'd0});
        end
    endtask

    task automatic probe_outputs_zero(input string nm);
        probe_q.push_back('{{nm, "_busy"}, P_BUSY, 32'd0});
        probe_q.push_back('{{nm, "_ren"}, P_REN, 32'd0});
        probe_q.push_back('{{nm, "_wen"}, P_WEN, 32'd0});
        probe_q.push_back('{{nm, "_addr"}, P_ADDR, 32'd0});
        probe_q.push_back('{{nm, "_wdata"}, P_WDATA, 32'd0});
        probe_q.push_back('{{nm, "_rdata"}, P_RDATA, 32'd0});
    endtask

    initial begin
        int snap;
        int n;
        int beats;
        for (int i = 0; i < 1024; i++) refm[i] = init_word(i);
        rst       = 1'b1;
        req_addr  = 32'h0;
        req_ren   = 1'b0;
        req_wen   = 1'b0;
        req_mask  = 4'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_load = 1'b0;
        chk_mem  = 1'b1;
        probe_outputs_zero("reset");
        @(posedge clk);

        // Read miss with a line fill, then a same-cycle partial-mask hit.
        snap = rd_accepts;
        issue(1'b0, 32'h100, 4'hF, 32'h0, 1'b0, "miss_0x100_busy");
        probe_q.push_back('{"fill_reads", P_RDACC, 32'(snap + 4)});
        snap = rd_accepts;
        issue(1'b0, 32'h104, 4'b0011, 32'h0, 1'b1, "hit_0x104_busy");
        probe_q.push_back('{"hit_no_mem_reads", P_RDACC, 32'(snap)});

        // Write hit with memory stalling three cycles.
        rdy_low = 3;
        snap = wen_cycles;
        issue(1'b1, 32'h108, 4'b0100, 32'hAABB_CCDD, 1'b1, "whit_0x108_busy");
        probe_q.push_back('{"wen_hold_cycles", P_WENCYC, 32'(snap + 4)});
        rdy_low = 0;
`ifdef CACHE_PERF_CNT_EN
        probe_q.push_back('{"hit_cnt", P_HITS, 32'd2});
        probe_q.push_back('{"miss_cnt", P_MISSES, 32'd1});
`endif
        issue(1'b0, 32'h108, 4'hF, 32'h0, 1'b1, "readback_0x108_busy");

        // Empty mask writes the unchanged word; write miss allocates then merges.
        issue(1'b1, 32'h10C, 4'b0000, 32'hFFFF_FFFF, 1'b1, "whit_mask0_busy");
        issue(1'b0, 32'h10C, 4'hF, 32'h0, 1'b1, "readback_0x10C_busy");
        issue(1'b1, 32'hA50, 4'b1001, 32'hDEAD_BEEF, 1'b0, "wmiss_0xA50_busy");
        issue(1'b0, 32'hA50, 4'hF, 32'h0, 1'b1, "readback_0xA50_busy");

        // Four tags into set 0: round-robin eviction.
        issue(1'b0, 32'h000, 4'hF, 32'h0, 1'b0, "set0_A_busy");
        issue(1'b0, 32'h204, 4'hF, 32'h0, 1'b0, "set0_B_busy");
        issue(1'b0, 32'h408, 4'hF, 32'h0, 1'b0, "set0_C_busy");
        issue(1'b0, 32'h60C, 4'hF, 32'h0, 1'b0, "set0_D_busy");
        issue(1'b0, 32'h400, 4'hF, 32'h0, 1'b1, "set0_C_hit_busy");
        issue(1'b0, 32'h600, 4'hF, 32'h0, 1'b1, "set0_D_hit_busy");
        issue(1'b0, 32'h004, 4'hF, 32'h0, 1'b0, "set0_A_remiss_busy");

        // Reset on the second fill beat aborts the fill.
        @(posedge clk); #1;
        chk_mem  = 1'b0;
        req_addr = 32'h300;
        req_mask = 4'hF;
        req_ren  = 1'b1;
        @(posedge clk); #1;
        req_ren = 1'b0;
        n = 0;
        beats = 0;
        while ((beats < 2) && (n < 100)) begin
            @(negedge clk);
            n++;
            if (i_mem_valid) beats++;
        end
        if (beats < 2) probe_q.push_back('{"timeout_fill_beat", P_RDACC, 32'hFFFF_FFFF});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        probe_outputs_zero("abort");
        repeat (6) @(posedge clk);
        #1;
        chk_mem = 1'b1;
        issue(1'b0, 32'h300, 4'hF, 32'h0, 1'b0, "after_abort_miss_busy");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
